// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester data-memory arbiter. The CPU has priority; the
// external port is forced through after STARVE_MAX consecutive CPU grants
// while it waits. Each access is IDLE -> ISSUE -> RESP (ack two cycles
// after the request is seen in IDLE).
//
// Optional build macro: DM_ARB_ALIGN_CHK_EN
//   defined   : misaligned CPU word/half stores are suppressed and
//               err_misalign pulses together with cpu_ack
//   undefined : no alignment check, err_misalign is constant 0
//
// Ports
//   clk, reset                    system clock, synchronous active-high reset
//   cpu_req/we/size/addr/wdata    CPU request (size 01/00 word, 10 half, 11 byte)
//   cpu_rdata, cpu_ack, cpu_stall CPU response
//   ext_req/we/addr/wdata         external requester, word accesses only
//   ext_rdata, ext_ack            external response
//   mem_addr/wdata/byteen         synchronous memory request (valid in ISSUE)
//   mem_rdata                     memory read data, valid one cycle after address
//   err_misalign                  misalignment pulse (see macro above)
//
// state | meaning
// IDLE  | arbitrate, latch the winner's request
// ISSUE | drive address / write data / byte enables to memory
// RESP  | return mem_rdata to the winner and pulse its ack
module dm_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic [31:0] ext_rdata,
    output logic        ext_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_rdata,
    output logic        err_misalign
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          win_ext_q, win_ext_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic [31:0]   ext_rdata_q, ext_rdata_d;

    logic          grant_any, grant_ext;
    logic          in_issue, in_resp;
    logic          is_half, is_byte, misalign;
    logic [3:0]    be_raw;
    logic [31:0]   wd_lane;

    assign grant_any = cpu_req | ext_req;
    // ext wins when it is alone or when the CPU has starved it long enough
    assign grant_ext = ext_req & (~cpu_req | (streak_q == SW'(STARVE_MAX)));

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        win_ext_d = win_ext_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d   = ST_ISSUE;
                    win_ext_d = grant_ext;
                    if (grant_ext) begin
                        we_d    = ext_we;
                        size_d  = 2'b01;
                        addr_d  = ext_addr;
                        wdata_d = ext_wdata;
                    end else begin
                        we_d    = cpu_we;
                        size_d  = cpu_size;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (!ext_req) begin
            streak_d = '0;
        end else if (state_q == ST_IDLE && grant_any) begin
            if (grant_ext) begin
                streak_d = '0;
            end else if (streak_q != SW'(STARVE_MAX)) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    assign in_issue = (state_q == ST_ISSUE);
    assign in_resp  = (state_q == ST_RESP);
    assign is_half  = (size_q == 2'b10);
    assign is_byte  = (size_q == 2'b11);

    always_comb begin
        be_raw  = 4'b1111;
        wd_lane = wdata_q;
        if (is_byte) begin
            be_raw  = 4'b0001 << addr_q[1:0];
            wd_lane = {24'h0, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
        end else if (is_half) begin
            be_raw  = addr_q[1] ? 4'b1100 : 4'b0011;
            wd_lane = addr_q[1] ? {wdata_q[15:0], 16'h0} : {16'h0, wdata_q[15:0]};
        end
    end

`ifdef DM_ARB_ALIGN_CHK_EN
    assign misalign = ~win_ext_q &
                      ((~is_half & ~is_byte & (addr_q[1:0] != 2'b00)) |
                       (is_half & addr_q[0]));
`else
    assign misalign = 1'b0;
`endif

    assign mem_addr   = in_issue ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = in_issue ? wd_lane : 32'h0;
    assign mem_byteen = (in_issue & we_q & ~misalign) ? be_raw : 4'b0000;

    assign cpu_ack      = in_resp & ~win_ext_q;
    assign ext_ack      = in_resp & win_ext_q;
    assign cpu_stall    = cpu_req & ~cpu_ack;
    assign err_misalign = cpu_ack & misalign;

    // read data is visible during the ack cycle and held afterwards
    assign cpu_rdata_d = cpu_ack ? mem_rdata : cpu_rdata_q;
    assign ext_rdata_d = ext_ack ? mem_rdata : ext_rdata_q;
    assign cpu_rdata   = cpu_rdata_d;
    assign ext_rdata   = ext_rdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            streak_q    <= '0;
            win_ext_q   <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            cpu_rdata_q <= 32'h0;
            ext_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            win_ext_q   <= win_ext_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed transactions with a response scoreboard
// and a small synchronous-read memory model.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic        ext_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byteen;
    logic        err_misalign;

`ifdef DM_ARB_ALIGN_CHK_EN
    localparam logic [3:0] MIS_BE  = 4'b0000;
    localparam logic       MIS_ERR = 1'b1;
`else
    localparam logic [3:0] MIS_BE  = 4'b1100;
    localparam logic       MIS_ERR = 1'b0;
`endif

    dm_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
        .mem_rdata(mem_rdata), .err_misalign(err_misalign)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // memory model: byte-enabled write, registered read
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[8] <= 32'h1234_5678;
            mem[9] <= 32'hCAFE_F00D;
            mem_rdata <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_byteen[b]) mem[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            mem_rdata <= mem[mem_addr[7:2]];
        end
    end

    typedef struct {
        bit          ext;
        bit          chk_rd;
        logic [31:0] rd;
    } sb_t;
    sb_t sb[$];

    task automatic sb_push(input bit ext, input bit chk_rd, input logic [31:0] rd);
        sb_t e;
        e.ext = ext;
        e.chk_rd = chk_rd;
        e.rd = rd;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (cpu_ack || ext_ack) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_ack", 32'(1), 32'(0));
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("ack_port", 32'(ext_ack), 32'(e.ext));
                chk("ack_both", 32'(cpu_ack & ext_ack), 32'(0));
                if (e.chk_rd) chk("rdata", e.ext ? ext_rdata : cpu_rdata, e.rd);
            end
        end
    end

    task automatic txn(input bit ext, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] e_maddr, input logic [3:0] e_be,
                       input logic [31:0] e_wd, input bit chk_rd,
                       input logic [31:0] e_rd, input logic e_err, input bit drop);
        @(negedge clk);
        if (ext) begin
            ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
        end
        sb_push(ext, chk_rd, e_rd);
        #1;
        if (!ext) chk("stall_req", 32'(cpu_stall), 32'(1));
        @(negedge clk);
        // later input changes must not disturb the latched request
        if (ext) begin
            ext_addr = ~addr; ext_wdata = ~wdata; ext_we = ~we;
            if (drop) ext_req = 1'b0;
        end else begin
            cpu_addr = ~addr; cpu_wdata = ~wdata; cpu_we = ~we; cpu_size = ~size;
            if (drop) cpu_req = 1'b0;
        end
        #1;
        chk("mem_addr", mem_addr, e_maddr);
        chk("mem_byteen", 32'(mem_byteen), 32'(e_be));
        if (we) chk("mem_wdata", mem_wdata, e_wd);
        if (!ext) chk("stall_issue", 32'(cpu_stall), 32'(!drop));
        @(negedge clk);
        #1;
        chk("ack_n2", 32'(ext ? ext_ack : cpu_ack), 32'(1));
        chk("err_misalign", 32'(err_misalign), 32'(e_err));
        if (!ext) chk("stall_ack", 32'(cpu_stall), 32'(0));
        cpu_req = 1'b0;
        ext_req = 1'b0;
        @(negedge clk);
        #1;
        chk("ack_pulse", 32'(cpu_ack | ext_ack), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, last, lat;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b01; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cpu_ack", 32'(cpu_ack), 32'(0));
        chk("rst_ext_ack", 32'(ext_ack), 32'(0));
        chk("rst_byteen", 32'(mem_byteen), 32'(0));
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_ext_rdata", ext_rdata, 32'h0);
        chk("rst_err", 32'(err_misalign), 32'(0));
        reset = 1'b0;

        //  ext we  size   addr          wdata          maddr         be       wd             rd rdata          err      drop
        txn(0, 1, 2'b11, 32'h0000_0013, 32'h0000_00AB, 32'h10, 4'b1000, 32'hAB00_0000, 0, 32'h0,          1'b0,    0);
        txn(0, 0, 2'b01, 32'h0000_0020, 32'h0,         32'h20, 4'b0000, 32'h0,         1, 32'h1234_5678, 1'b0,    0);
        txn(0, 1, 2'b10, 32'h0000_0003, 32'h0000_1234, 32'h00, MIS_BE,  32'h1234_0000, 0, 32'h0,          MIS_ERR, 0);
        txn(0, 1, 2'b00, 32'h0000_0040, 32'h1122_3344, 32'h40, 4'b1111, 32'h1122_3344, 0, 32'h0,          1'b0,    0);
        txn(0, 1, 2'b10, 32'h0000_0042, 32'h0000_BEEF, 32'h40, 4'b1100, 32'hBEEF_0000, 0, 32'h0,          1'b0,    0);
        txn(0, 1, 2'b11, 32'h0000_0041, 32'h0000_0077, 32'h40, 4'b0010, 32'h0000_7700, 0, 32'h0,          1'b0,    0);
        txn(0, 1, 2'b11, 32'h0000_0044, 32'hFFFF_FF5A, 32'h44, 4'b0001, 32'h0000_005A, 0, 32'h0,          1'b0,    0);
        txn(0, 0, 2'b01, 32'h0000_0040, 32'h0,         32'h40, 4'b0000, 32'h0,         1, 32'hBEEF_7744, 1'b0,    0);
        txn(1, 0, 2'b01, 32'h0000_0027, 32'h0,         32'h24, 4'b0000, 32'h0,         1, 32'hCAFE_F00D, 1'b0,    0);
        txn(1, 1, 2'b01, 32'h0000_0050, 32'hA5A5_A5A5, 32'h50, 4'b1111, 32'hA5A5_A5A5, 0, 32'h0,          1'b0,    0);
        txn(0, 0, 2'b01, 32'h0000_0020, 32'h0,         32'h20, 4'b0000, 32'h0,         1, 32'h1234_5678, 1'b0,    1);

        // both requesters held: four CPU grants, then one ext grant, repeated
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b01; cpu_addr = 32'h20;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h24;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) sb_push(1, 1, 32'hCAFE_F00D);
            else sb_push(0, 1, 32'h1234_5678);
        end
        got = 0;
        last = 0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge clk);
            #1;
            if (cpu_ack || ext_ack) begin
                if (got > 0) chk("ack_spacing", 32'(c - last), 32'(3));
                last = c;
                got++;
            end
        end
        cpu_req = 1'b0;
        ext_req = 1'b0;
        chk("starve_acks", 32'(got), 32'(10));

        // reset during ISSUE of an ext store aborts it; held req is re-served
        repeat (2) @(negedge clk);
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h30; ext_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        chk("abort_issue_be", 32'(mem_byteen), 32'(4'b1111));
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_be", 32'(mem_byteen), 32'(0));
        chk("abort_ext_ack", 32'(ext_ack), 32'(0));
        chk("abort_cpu_rdata", cpu_rdata, 32'h0);
        chk("abort_ext_rdata", ext_rdata, 32'h0);
        reset = 1'b0;
        sb_push(1, 0, 32'h0);
        lat = -1;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            #1;
            if (ext_ack) lat = c;
        end
        ext_req = 1'b0;
        chk("abort_reserve_lat", 32'(lat), 32'(2));

        repeat (4) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
